// File: rtl/vga_pkg.sv
// Shared VGA raster constants and coordinate type. The pixel stages import this
// as well, so their address scaling matches the timing generator.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

endpackage

// File: rtl/vga_sync_delay.sv
// Reset-to-1 shift register for the {hs, vs} pair, so the sync lines idle
// inactive (high) while the delay line is flushed by reset.
module vga_sync_delay #(
    parameter int DEPTH = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [1:0] sync_in,
    output logic [1:0] sync_out
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign sync_out = sync_in;
        end else begin : g_pipe
            logic [1:0] stages [DEPTH];

            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= 2'b11;
                end else begin
                    stages[0] <= sync_in;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign sync_out = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters with registered blank/frame_start/sync decode.
// Syncs are delayed SYNC_DELAY cycles to line up with the registered pixel colour.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int SYNC_DELAY = 1
) (
    input  logic   vga_clk,
    input  logic   reset,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   blank,
    output logic   hs,
    output logic   vs,
    output logic   frame_start
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_BEGIN = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_BEGIN = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t hc, vc;
    coord_t hc_nxt, vc_nxt;
    logic   h_wrap;
    logic   blank_nxt, fs_nxt, hs_nxt, vs_nxt;
    logic   hs_raw, vs_raw;

    // Decode from the next-state counters so every flag is registered
    // alongside the coordinate it describes.
    always_comb begin
        h_wrap    = (hc == H_LAST);
        hc_nxt    = h_wrap ? '0 : hc + 1'b1;
        vc_nxt    = vc;
        if (h_wrap) begin
            vc_nxt = (vc == V_LAST) ? '0 : vc + 1'b1;
        end
        blank_nxt = (hc_nxt < H_VIS_C) && (vc_nxt < V_VIS_C);
        fs_nxt    = (hc_nxt == '0) && (vc_nxt == '0);
        hs_nxt    = !((hc_nxt >= HS_BEGIN) && (hc_nxt < HS_END));
        vs_nxt    = !((vc_nxt >= VS_BEGIN) && (vc_nxt < VS_END));
    end

    // Reset parks on the last pixel so the first edge after release lands on (0,0).
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc          <= H_LAST;
            vc          <= V_LAST;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
        end else begin
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            blank       <= blank_nxt;
            frame_start <= fs_nxt;
            hs_raw      <= hs_nxt;
            vs_raw      <= vs_nxt;
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;

    vga_sync_delay #(
        .DEPTH(SYNC_DELAY)
    ) u_sync_delay (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .sync_in  ({hs_raw, vs_raw}),
        .sync_out ({hs, vs})
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing at sync delays 0/1/3 plus a
// shrunken-raster instance for whole-frame and mid-sync reset behaviour.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    logic [9:0] x0, y0, x1, y1, x3, y3, xs, ys;
    logic b0, hs0, vs0, fs0;
    logic b1, hs1, vs1, fs1;
    logic b3, hs3, vs3, fs3;
    logic bs, hss, vss, fss;

    int checks   = 0;
    int failures = 0;

    int mx, my, sx, sy;
    logic [1:0] hist [4];
    logic [1:0] shist [2];
    logic [31:0] exp_q [$];
    int step_n;
    int fs_seen;
    int vs_low;
    bit found;

    // clock
    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(.SYNC_DELAY(0)) dut_d0 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(x0), .DrawY(y0),
        .blank(b0), .hs(hs0), .vs(vs0), .frame_start(fs0));

    vga_timing_gen #(.SYNC_DELAY(1)) dut_d1 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(x1), .DrawY(y1),
        .blank(b1), .hs(hs1), .vs(vs1), .frame_start(fs1));

    vga_timing_gen #(.SYNC_DELAY(3)) dut_d3 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(x3), .DrawY(y3),
        .blank(b3), .hs(hs3), .vs(vs3), .frame_start(fs3));

    // 15 x 8 raster: visible 8x4, hsync at 10..12, vsync on lines 5..6
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_DELAY(1)
    ) dut_s (
        .vga_clk(vga_clk), .reset(reset), .DrawX(xs), .DrawY(ys),
        .blank(bs), .hs(hss), .vs(vss), .frame_start(fss));

    function automatic logic [1:0] ideal_big(input int x, input int y);
        return {!(x >= 656 && x < 752), !(y >= 490 && y < 492)};
    endfunction

    function automatic logic [1:0] ideal_small(input int x, input int y);
        return {!(x >= 10 && x < 13), !(y >= 5 && y < 7)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 799; my = 524;
        sx = 14;  sy = 7;
        for (int i = 0; i < 4; i++) hist[i] = 2'b11;
        for (int i = 0; i < 2; i++) shist[i] = 2'b11;
    endtask

    // one pixel clock: wait for the sampling edge, advance the reference raster
    task automatic step();
        @(negedge vga_clk);
        step_n++;
        if (mx == 799) begin
            mx = 0;
            my = (my == 524) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        if (sx == 14) begin
            sx = 0;
            sy = (sy == 7) ? 0 : sy + 1;
        end else begin
            sx = sx + 1;
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0]  = ideal_big(mx, my);
        shist[1] = shist[0];
        shist[0] = ideal_small(sx, sy);
    endtask

    task automatic check_all();
        check("d0_x",     32'(x0), 32'(mx));
        check("d0_y",     32'(y0), 32'(my));
        check("d0_blank", 32'(b0), 32'(mx < 640 && my < 480));
        check("d0_fs",    32'(fs0), 32'(mx == 0 && my == 0));
        check("d0_hs",    32'(hs0), 32'(hist[0][1]));
        check("d0_vs",    32'(vs0), 32'(hist[0][0]));
        check("d1_x",     32'(x1), 32'(mx));
        check("d1_hs",    32'(hs1), 32'(hist[1][1]));
        check("d1_vs",    32'(vs1), 32'(hist[1][0]));
        check("d3_x",     32'(x3), 32'(mx));
        check("d3_blank", 32'(b3), 32'(mx < 640 && my < 480));
        check("d3_hs",    32'(hs3), 32'(hist[3][1]));
        check("d3_vs",    32'(vs3), 32'(hist[3][0]));
        check("s_x",      32'(xs), 32'(sx));
        check("s_y",      32'(ys), 32'(sy));
        check("s_blank",  32'(bs), 32'(sx < 8 && sy < 4));
        check("s_fs",     32'(fss), 32'(sx == 0 && sy == 0));
        check("s_hs",     32'(hss), 32'(shist[1][1]));
        check("s_vs",     32'(vss), 32'(shist[1][0]));
    endtask

    initial begin
        // reset held for 5 cycles
        reset = 1'b1;
        model_reset();
        repeat (5) begin
            @(negedge vga_clk);
            check_all();
        end
        reset = 1'b0;

        // one full default line plus wrap; two complete small frames inside it
        step_n  = 0;
        fs_seen = 0;
        vs_low  = 0;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd121);
        for (int i = 0; i < 802; i++) begin
            step();
            check_all();
            if (step_n <= 240) begin
                if (!vss) vs_low++;
                if (fss) begin
                    fs_seen++;
                    if (exp_q.size() > 0) check("s_fs_step", 32'(step_n), exp_q.pop_front());
                    else check("s_fs_extra", 32'(step_n), 32'd0);
                end
            end
        end
        check("s_fs_count", 32'(fs_seen), 32'd2);
        check("s_vs_low_cycles", 32'(vs_low), 32'd60);
        check("s_fs_pending", 32'(exp_q.size()), 32'd0);

        // move the small raster into its sync pulse (DrawX=11, DrawY=5)
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            check_all();
            if (sx == 11 && sy == 5) found = 1'b1;
        end
        check("s_reach_sync", 32'(found), 32'd1);
        check("s_hs_in_pulse", 32'(hss), 32'd0);
        check("s_vs_in_pulse", 32'(vss), 32'd0);

        // asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (3) begin
            @(negedge vga_clk);
            check_all();
        end
        reset = 1'b0;

        // restart at (0,0) with frame_start, then a few more pixels
        for (int i = 0; i < 4; i++) begin
            step();
            check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
